fpu_xfer_ctrl: RTL and testbench



---
 rtl/fpu_xfer_pkg.sv | 28 ++
 rtl/fpu_xfer_fifo.sv | 58 +++++
 rtl/fpu_xfer_ctrl.sv | 127 ++++++++++++
 tb/tb_fpu_xfer_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_xfer_pkg.sv
// Shared encodings, constants and the result-queue entry layout for the FPU transfer stage.
package fpu_xfer_pkg;

    localparam int unsigned DATA_W     = 64;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned OP_W       = 3;
    localparam int unsigned XFER_TAG_W = 5;

    localparam logic [OP_W-1:0] OP_MOV_INT_FP = 3'b000;
    localparam logic [OP_W-1:0] OP_MOV_FP_INT = 3'b001;
    localparam logic [OP_W-1:0] OP_FCLASS     = 3'b100;

    localparam logic [WORD_W-1:0] CANON_NAN_SP = 32'h7FC0_0000;
    localparam logic [WORD_W-1:0] BOX_ONES     = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [DATA_W-1:0]     data;
        logic [XFER_TAG_W-1:0] tag;
        logic                  to_fp;
        logic                  illegal;
    } res_entry_t;

    // A single-precision value is valid only when its upper word is all ones.
    function automatic logic is_boxed(input logic [DATA_W-1:0] d);
        return d[DATA_W-1:WORD_W] == BOX_ONES;
    endfunction

endpackage

// File: rtl/fpu_xfer_fifo.sv
// Small synchronous FIFO with flush; head entry is presented directly on rdata.
module fpu_xfer_fifo #(
    parameter  int unsigned DEPTH = 2,
    parameter  int unsigned W     = 8,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && (count != CW'(0));
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign rdata   = mem[rptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else if (do_push && !flush) begin
            mem[wptr] <= wdata;
        end
    end

endmodule

// File: rtl/fpu_xfer_ctrl.sv
// Request register, transfer-unit drive and result formatting/queueing for FMV/FCLASS.
module fpu_xfer_ctrl
    import fpu_xfer_pkg::*;
#(
    parameter int unsigned TAG_W = XFER_TAG_W,
    parameter int unsigned DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic              req_sp_dp,
    input  logic [63:0]       req_data,
    input  logic [TAG_W-1:0]  req_tag,
    output logic [63:0]       xfer_input,
    output logic              xfer_sp_dp,
    output logic [2:0]        xfer_operation,
    input  logic [31:0]       xfer_output,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [63:0]       res_data,
    output logic [TAG_W-1:0]  res_tag,
    output logic              res_to_fp,
    output logic              res_illegal
);

    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned ENTRY_W = $bits(res_entry_t);

    logic              s1_valid;
    logic [OP_W-1:0]   s1_op;
    logic              s1_sp_dp;
    logic [DATA_W-1:0] s1_data;
    logic [TAG_W-1:0]  s1_tag;

    logic [CNT_W-1:0]  count;
    logic              full;
    logic              accept;
    logic              push;
    logic              pop;
    res_entry_t        wr_entry;
    res_entry_t        head;

    assign full      = (count == CNT_W'(DEPTH));
    assign req_ready = !s1_valid || !full;
    assign accept    = req_valid && req_ready;
    assign res_valid = (count != CNT_W'(0));
    assign pop       = res_valid && res_ready;
    assign push      = s1_valid && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_sp_dp <= 1'b0;
            s1_data  <= '0;
            s1_tag   <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= accept || (s1_valid && !push);
            if (accept) begin
                s1_op    <= req_op;
                s1_sp_dp <= req_sp_dp;
                s1_data  <= req_data;
                s1_tag   <= req_tag;
            end
        end
    end

    // Unboxed SP sources read as canonical NaN for FP-to-int moves and classify.
    always_comb begin
        xfer_input     = '0;
        xfer_sp_dp     = 1'b0;
        xfer_operation = '0;
        if (s1_valid) begin
            xfer_input     = s1_data;
            xfer_sp_dp     = s1_sp_dp;
            xfer_operation = s1_op;
            if (!s1_sp_dp && !is_boxed(s1_data) &&
                (s1_op == OP_FCLASS || s1_op == OP_MOV_FP_INT))
                xfer_input[WORD_W-1:0] = CANON_NAN_SP;
        end
    end

    always_comb begin
        wr_entry         = '0;
        wr_entry.tag     = XFER_TAG_W'(s1_tag);
        case (s1_op)
            OP_MOV_INT_FP: begin
                wr_entry.to_fp = 1'b1;
                wr_entry.data  = s1_sp_dp ? s1_data : {BOX_ONES, xfer_output};
            end
            OP_MOV_FP_INT: begin
                wr_entry.data  = s1_sp_dp ? s1_data : {{WORD_W{xfer_output[WORD_W-1]}}, xfer_output};
            end
            OP_FCLASS: begin
                wr_entry.data  = {54'b0, xfer_output[9:0]};
            end
            default: begin
                wr_entry.illegal = 1'b1;
            end
        endcase
    end

    fpu_xfer_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (head),
        .count (count)
    );

    assign res_data    = head.data;
    assign res_tag     = TAG_W'(head.tag);
    assign res_to_fp   = head.to_fp;
    assign res_illegal = head.illegal;

endmodule

// File: tb/tb_fpu_xfer_ctrl.sv
// Directed bench for fpu_xfer_ctrl with a behavioural SP transfer/classify unit model.
module tb_fpu_xfer_ctrl;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic        req_sp_dp;
    logic [63:0] req_data;
    logic [4:0]  req_tag;
    logic [63:0] xfer_input;
    logic        xfer_sp_dp;
    logic [2:0]  xfer_operation;
    logic [31:0] xfer_output;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] res_data;
    logic [4:0]  res_tag;
    logic        res_to_fp;
    logic        res_illegal;

    int checks;
    int failures;

    fpu_xfer_ctrl #(.TAG_W(5), .DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_sp_dp      (req_sp_dp),
        .req_data       (req_data),
        .req_tag        (req_tag),
        .xfer_input     (xfer_input),
        .xfer_sp_dp     (xfer_sp_dp),
        .xfer_operation (xfer_operation),
        .xfer_output    (xfer_output),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_data       (res_data),
        .res_tag        (res_tag),
        .res_to_fp      (res_to_fp),
        .res_illegal    (res_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] fclass_sp(input logic [31:0] f);
        logic        s;
        logic [7:0]  e;
        logic [22:0] m;
        s = f[31];
        e = f[30:23];
        m = f[22:0];
        if (e == 8'hFF) begin
            if (m == 23'd0) return s ? 10'h001 : 10'h080;
            return m[22] ? 10'h200 : 10'h100;
        end
        if (e == 8'h00) begin
            if (m == 23'd0) return s ? 10'h008 : 10'h010;
            return s ? 10'h004 : 10'h020;
        end
        return s ? 10'h002 : 10'h040;
    endfunction

    // Transfer unit model: SP moves pass the low word through, FCLASS classifies it.
    always_comb begin
        xfer_output = 32'h0;
        case (xfer_operation)
            3'b000, 3'b001: xfer_output = xfer_input[31:0];
            3'b100:         xfer_output = {22'b0, fclass_sp(xfer_input[31:0])};
            default:        xfer_output = 32'h0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [2:0] op, input logic sp_dp, input logic [63:0] data,
                        input logic [4:0] tag);
        req_valid = 1'b1;
        req_op    = op;
        req_sp_dp = sp_dp;
        req_data  = data;
        req_tag   = tag;
        tick();
        req_valid = 1'b0;
    endtask

    function automatic logic [63:0] bp_data(input int k);
        return 64'hCAFE_0000_0000_1000 + 64'(k) * 64'h0000_0001_0000_0001;
    endfunction

    int          k;
    logic [63:0] held;

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        req_valid = 1'b0;
        req_op    = 3'b000;
        req_sp_dp = 1'b0;
        req_data  = 64'h0;
        req_tag   = 5'd0;
        res_ready = 1'b1;
        tick();
        tick();

        chk("rst_res_valid",   64'(res_valid),      64'd0);
        chk("rst_res_data",    res_data,            64'd0);
        chk("rst_res_tag",     64'(res_tag),        64'd0);
        chk("rst_res_to_fp",   64'(res_to_fp),      64'd0);
        chk("rst_res_illegal", 64'(res_illegal),    64'd0);
        chk("rst_req_ready",   64'(req_ready),      64'd1);
        chk("rst_xfer_input",  xfer_input,          64'd0);
        chk("rst_xfer_op",     64'(xfer_operation), 64'd0);
        rst_n = 1'b1;
        tick();

        // SP int->fp move is NaN-boxed two cycles after accept.
        send(3'b000, 1'b0, 64'h0000_0000_3F80_0000, 5'd3);
        chk("mif_xfer_input", xfer_input, 64'h0000_0000_3F80_0000);
        chk("mif_res_valid_early", 64'(res_valid), 64'd0);
        tick();
        chk("mif_res_valid", 64'(res_valid), 64'd1);
        chk("mif_res_data",  res_data,       64'hFFFF_FFFF_3F80_0000);
        chk("mif_res_tag",   64'(res_tag),   64'd3);
        chk("mif_res_to_fp", 64'(res_to_fp), 64'd1);
        tick();
        chk("mif_popped", 64'(res_valid), 64'd0);

        // FCLASS of an unboxed SP value classifies the canonical NaN.
        send(3'b100, 1'b0, 64'h0000_0000_3F80_0000, 5'd4);
        chk("fcl_unbox_input", xfer_input, 64'h0000_0000_7FC0_0000);
        tick();
        chk("fcl_unbox_data",  res_data,       64'h200);
        chk("fcl_unbox_to_fp", 64'(res_to_fp), 64'd0);
        tick();
        send(3'b100, 1'b0, 64'hFFFF_FFFF_FF80_0000, 5'd5);
        chk("fcl_box_input", xfer_input, 64'hFFFF_FFFF_FF80_0000);
        tick();
        chk("fcl_neginf_data", res_data, 64'h001);
        tick();

        // FP->int moves: SP sign-extends, DP passes through.
        send(3'b001, 1'b0, 64'hFFFF_FFFF_8000_0001, 5'd6);
        tick();
        chk("mfi_sp_data",  res_data,       64'hFFFF_FFFF_8000_0001);
        chk("mfi_sp_to_fp", 64'(res_to_fp), 64'd0);
        tick();
        send(3'b001, 1'b1, 64'h1234_5678_9ABC_DEF0, 5'd7);
        chk("mfi_dp_sp_dp", 64'(xfer_sp_dp), 64'd1);
        tick();
        chk("mfi_dp_data", res_data,     64'h1234_5678_9ABC_DEF0);
        chk("mfi_dp_tag",  64'(res_tag), 64'd7);
        tick();

        // Full throughput with the writeback side always ready.
        for (int i = 0; i < 5; i++) begin
            req_valid = (i < 3);
            req_op    = 3'b000;
            req_sp_dp = 1'b1;
            req_data  = bp_data(20 + i);
            req_tag   = 5'(20 + i);
            if (i < 3) chk("tput_req_ready", 64'(req_ready), 64'd1);
            if (i >= 2) chk("tput_res_data", res_data, bp_data(20 + i - 2));
            tick();
        end
        req_valid = 1'b0;
        tick();
        chk("tput_drained", 64'(res_valid), 64'd0);

        // Backpressure: only DEPTH+1 requests fit while writeback is stalled.
        res_ready = 1'b0;
        k = 0;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1;
            req_op    = 3'b000;
            req_sp_dp = 1'b1;
            req_data  = bp_data(k);
            req_tag   = 5'(10 + k);
            if (req_ready) k++;
            tick();
        end
        req_valid = 1'b0;
        chk("bp_accepted",  64'(k),         64'd3);
        chk("bp_req_ready", 64'(req_ready), 64'd0);
        held = res_data;
        chk("bp_head", held, bp_data(0));
        tick();
        tick();
        chk("bp_stable_data",  res_data,       held);
        chk("bp_stable_tag",   64'(res_tag),   64'd10);
        chk("bp_stable_valid", 64'(res_valid), 64'd1);
        res_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            chk("bp_drain_valid", 64'(res_valid), 64'd1);
            chk("bp_drain_data",  res_data,       bp_data(j));
            chk("bp_drain_tag",   64'(res_tag),   64'(10 + j));
            tick();
        end
        chk("bp_empty", 64'(res_valid), 64'd0);
        chk("bp_ready_again", 64'(req_ready), 64'd1);

        // Unsupported opcode.
        send(3'b111, 1'b0, 64'h5555_AAAA_5555_AAAA, 5'd9);
        chk("ill_xfer_op", 64'(xfer_operation), 64'd7);
        tick();
        chk("ill_flag",  64'(res_illegal), 64'd1);
        chk("ill_data",  res_data,         64'd0);
        chk("ill_to_fp", 64'(res_to_fp),   64'd0);
        tick();

        // Flush with two queued results and a competing request.
        res_ready = 1'b0;
        send(3'b000, 1'b1, 64'h0101_0101_0101_0101, 5'd1);
        send(3'b000, 1'b1, 64'h0202_0202_0202_0202, 5'd2);
        tick();
        chk("fl_pre_valid", 64'(res_valid), 64'd1);
        chk("fl_pre_ready", 64'(req_ready), 64'd1);
        flush     = 1'b1;
        req_valid = 1'b1;
        req_data  = 64'h0303_0303_0303_0303;
        tick();
        flush     = 1'b0;
        req_valid = 1'b0;
        chk("fl_res_valid",  64'(res_valid), 64'd0);
        chk("fl_req_ready",  64'(req_ready), 64'd1);
        chk("fl_not_accept", xfer_input,     64'd0);
        tick();
        chk("fl_still_empty", 64'(res_valid), 64'd0);

        // Asynchronous reset between edges discards queued work.
        send(3'b000, 1'b1, 64'h0404_0404_0404_0404, 5'd4);
        send(3'b001, 1'b1, 64'h0505_0505_0505_0505, 5'd5);
        chk("ar_pre_valid", 64'(res_valid), 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_res_valid", 64'(res_valid),   64'd0);
        chk("ar_res_data",  res_data,         64'd0);
        chk("ar_res_tag",   64'(res_tag),     64'd0);
        chk("ar_to_fp",     64'(res_to_fp),   64'd0);
        chk("ar_req_ready", 64'(req_ready),   64'd1);
        chk("ar_xfer_in",   xfer_input,       64'd0);
        tick();
        rst_n     = 1'b1;
        res_ready = 1'b1;
        tick();
        tick();
        chk("ar_post_valid", 64'(res_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
